// File: rtl/varshift_norm_if.sv
// Handshake and data bundle for the leading-sign normaliser.
// Carries the operand request (valid/ready/operand) and the result response
// (valid/ready/normalised value, shift amount, zero flag).
interface varshift_norm_if #(
    parameter int WIDTH = 64
);
    localparam int SHW = $clog2(WIDTH);

    logic             varnorm_valid_i;
    logic             varnorm_ready_o;
    logic [WIDTH-1:0] varnorm_i;
    logic             varnorm_valid_o;
    logic             varnorm_ready_i;
    logic [WIDTH-1:0] varnorm_o;
    logic [SHW-1:0]   varnorm_shamt_o;
    logic             varnorm_zero_o;

    // Upstream/downstream side: presents operands and consumes results.
    modport master (
        output varnorm_valid_i, varnorm_i, varnorm_ready_i,
        input  varnorm_ready_o, varnorm_valid_o, varnorm_o, varnorm_shamt_o, varnorm_zero_o
    );

    // Normaliser side.
    modport slave (
        input  varnorm_valid_i, varnorm_i, varnorm_ready_i,
        output varnorm_ready_o, varnorm_valid_o, varnorm_o, varnorm_shamt_o, varnorm_zero_o
    );
endinterface

// File: rtl/varshift_norm.sv
// Purpose: iterative leading-sign normaliser; left-shifts a signed operand by its redundant sign-bit count.
// Latency: result valid SHW cycles after the accept edge; one operand in flight, accepts spaced >= SHW+2 cycles.
// Backpressure: result held stable in DONE until varnorm_ready_i; varnorm_ready_o high only when idle.
//
// Ports: clk, rst_n (async active-low), bus (varshift_norm_if.slave):
//   varnorm_valid_i/varnorm_ready_o/varnorm_i             operand handshake
//   varnorm_valid_o/varnorm_ready_i/varnorm_o             result handshake
//   varnorm_shamt_o (redundant sign bits), varnorm_zero_o (operand was 0)
module varshift_norm #(
    parameter int WIDTH = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    varshift_norm_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   shamt;
    logic [SHW-1:0]   k;
    logic             zero_q;
    logic             ready_q;
    logic             valid_q;

    logic [SHW-1:0]   step;
    logic [WIDTH-1:0] top_mask;
    logic             sign_run;

    // Binary search step: the top step+1 bits all matching the MSB means
    // `step` more sign bits are redundant and can be shifted out safely.
    always_comb begin
        step     = SHW'(1) << k;
        top_mask = ~({WIDTH{1'b1}} >> (step + SHW'(1)));
        sign_run = ((work ^ {WIDTH{work[WIDTH-1]}}) & top_mask) == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            work    <= '0;
            shamt   <= '0;
            k       <= SHW'(SHW-1);
            zero_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.varnorm_valid_i) begin
                        work    <= bus.varnorm_i;
                        shamt   <= '0;
                        k       <= SHW'(SHW-1);
                        zero_q  <= (bus.varnorm_i == '0);
                        ready_q <= 1'b0;
                        state   <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (sign_run) begin
                        work  <= work << step;
                        shamt <= shamt + step;
                    end
                    // Fixed SHW iterations keep the latency data-independent.
                    if (k == '0) begin
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.varnorm_ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.varnorm_ready_o = ready_q;
    assign bus.varnorm_valid_o = valid_q;
    assign bus.varnorm_o       = work;
    assign bus.varnorm_shamt_o = shamt;
    assign bus.varnorm_zero_o  = zero_q;
endmodule
